// File: rtl/bidir_reg_pkg.sv
// rtl/bidir_reg_pkg.sv - shared mode type and priority decode for bidirectional_reg
package bidir_reg_pkg;

   // Operation selected for the next clock edge
   typedef enum logic [1:0] {
      MODE_HOLD,
      MODE_LOAD,
      MODE_SHR,
      MODE_SHL
   } bidir_mode_t;

   // Load beats any shift; rs and ls together are a conflict and hold
   function automatic bidir_mode_t decode_mode(
      input logic load,
      input logic rs,
      input logic ls
   );
      bidir_mode_t mode;
      if (load) begin
         mode = MODE_LOAD;
      end else if (rs && !ls) begin
         mode = MODE_SHR;
      end else if (ls && !rs) begin
         mode = MODE_SHL;
      end else begin
         mode = MODE_HOLD;
      end
      return mode;
   endfunction

endpackage

// File: rtl/bidirectional_reg_next.sv
// rtl/bidirectional_reg_next.sv - combinational next-state mux; BIDIR_REG_ROTATE_EN selects rotate instead of fill
module bidirectional_reg_next
   import bidir_reg_pkg::*;
#(
   parameter int   WIDTH    = 4,
   parameter logic FILL_BIT = 1'b0
) (
   input  bidir_mode_t      mode,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next
);

   logic shr_in;
   logic shl_in;

`ifdef BIDIR_REG_ROTATE_EN
   // Rotate: the bit leaving one end re-enters at the other
   assign shr_in = q[0];
   assign shl_in = q[WIDTH-1];
   wire unused_fill_bit = FILL_BIT;
`else
   // Shift: the vacated position takes the constant fill bit
   assign shr_in = FILL_BIT;
   assign shl_in = FILL_BIT;
`endif

   // Select the next register word for the decoded mode
   always_comb begin
      q_next = q;
      case (mode)
         MODE_LOAD: q_next = d;
         MODE_SHR:  q_next = {shr_in, q[WIDTH-1:1]};
         MODE_SHL:  q_next = {q[WIDTH-2:0], shl_in};
         MODE_HOLD: q_next = q;
         default:   q_next = q;
      endcase
   end

endmodule

// File: rtl/bidirectional_reg.sv
// rtl/bidirectional_reg.sv - parallel-load left/right shift register with async clear; honours BIDIR_REG_ROTATE_EN
module bidirectional_reg
   import bidir_reg_pkg::*;
#(
   parameter int   WIDTH    = 4,
   parameter logic FILL_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             rs,
   input  logic             ls,
   output logic [WIDTH-1:0] q
);

   bidir_mode_t      mode;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Resolve the control inputs into a single operation
   always_comb begin
      mode = decode_mode(load, rs, ls);
   end

   bidirectional_reg_next #(
      .WIDTH    (WIDTH),
      .FILL_BIT (FILL_BIT)
   ) u_next (
      .mode   (mode),
      .q      (q_q),
      .d      (d),
      .q_next (q_next)
   );

   // Next register contents come straight from the mux
   always_comb begin
      q_d = q_next;
   end

   // Storage bank; clr wins immediately regardless of clk
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_bidirectional_reg.sv
// tb/tb_bidirectional_reg.sv - directed and randomized bench for bidirectional_reg
module tb_bidirectional_reg;

   localparam int   W    = 4;
   localparam logic FILL = 1'b0;

   logic         clk;
   logic         clr;
   logic         load;
   logic [W-1:0] d;
   logic         rs;
   logic         ls;
   logic [W-1:0] q;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [W-1:0] model_q;

   bidirectional_reg #(
      .WIDTH    (W),
      .FILL_BIT (FILL)
   ) dut (
      .clk  (clk),
      .clr  (clr),
      .load (load),
      .d    (d),
      .rs   (rs),
      .ls   (ls),
      .q    (q)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Reference: the register as an integer value, shifts as divide/multiply
   function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic ld,
                                             input logic [W-1:0] dd, input logic r, input logic l);
      int v;
      int top;
      int in_bit;
      v   = int'(cur);
      top = 1 << (W - 1);
      if (ld) return dd;
      if (r && !l) begin
`ifdef BIDIR_REG_ROTATE_EN
         in_bit = v % 2;
`else
         in_bit = int'(FILL);
`endif
         return W'(v / 2 + in_bit * top);
      end
      if (l && !r) begin
`ifdef BIDIR_REG_ROTATE_EN
         in_bit = (v >= top) ? 1 : 0;
`else
         in_bit = int'(FILL);
`endif
         return W'((v * 2) % (top * 2) + in_bit);
      end
      return cur;
   endfunction

   // Drive controls away from the edge, clock once, then sample at the falling edge
   task automatic step(input logic ld, input logic [W-1:0] dd, input logic r, input logic l);
      load = ld;
      d    = dd;
      rs   = r;
      ls   = l;
      @(posedge clk);
      @(negedge clk);
      if (!clr) model_q = ref_next(model_q, ld, dd, r, l);
      else      model_q = '0;
   endtask

   initial begin
      logic [W-1:0] rd;
      logic         rl;
      logic         rr;
      logic         rlf;

      clr = 1'b0; load = 1'b0; d = '0; rs = 1'b0; ls = 1'b0;
      model_q = '0;

      // Asynchronous clear mid-cycle, then held across edges
      @(negedge clk);
      clr = 1'b1;
      #1;
      check("clr_async", q, 4'b0000);
      step(1'b1, 4'b1111, 1'b0, 1'b0);
      check("clr_hold_load", q, 4'b0000);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("clr_hold_shift", q, 4'b0000);
      clr = 1'b0;
      #1;
      check("clr_release", q, 4'b0000);

      // Load and hold
      step(1'b1, 4'b0110, 1'b0, 1'b0);
      check("load_0110", q, 4'b0110);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b1111, 1'b0, 1'b0);
         check("hold_0110", q, 4'b0110);
      end

      // Shifts right and left
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("shr_0110", q, 4'b0011);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
      check("shl_0011", q, 4'b0110);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
`ifdef BIDIR_REG_ROTATE_EN
      check("shl_0110", q, 4'b1100);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
      check("shl_1100", q, 4'b1001);
`else
      check("shl_0110", q, 4'b1100);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
      check("shl_1100", q, 4'b1000);
`endif

      // Conflicting shift holds; load beats shift
      step(1'b1, 4'b0110, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b1, 1'b1);
      check("conflict_hold", q, 4'b0110);
      step(1'b1, 4'b1010, 1'b1, 1'b0);
      check("load_wins", q, 4'b1010);

      // Fill versus rotate at both ends
      step(1'b1, 4'b1001, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
`ifdef BIDIR_REG_ROTATE_EN
      check("shr_1001", q, 4'b1100);
`else
      check("shr_1001", q, 4'b0100);
`endif
      step(1'b1, 4'b1001, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b1);
`ifdef BIDIR_REG_ROTATE_EN
      check("shl_1001", q, 4'b0011);
`else
      check("shl_1001", q, 4'b0010);
`endif

      // Clear aborts a shift run; release with rs still high keeps zeros
      step(1'b1, 4'b1011, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
`ifdef BIDIR_REG_ROTATE_EN
      check("run_shr1", q, 4'b1101);
`else
      check("run_shr1", q, 4'b0101);
`endif
      clr = 1'b1;
      #1;
      check("clr_mid_run", q, 4'b0000);
      model_q = '0;
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("clr_run_hold", q, 4'b0000);
      clr = 1'b0;
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("run_after_clr1", q, 4'b0000);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      check("run_after_clr2", q, 4'b0000);

      // Randomized traffic against the reference model
      model_q = q;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(15) == 0) begin
            clr = 1'b1;
            #1;
            check($sformatf("rand_clr%0d", i), q, 4'b0000);
            clr = 1'b0;
            model_q = '0;
         end
         rl  = ($urandom_range(3) == 0);
         rd  = W'($urandom);
         rr  = 1'($urandom);
         rlf = 1'($urandom);
         step(rl, rd, rr, rlf);
         check($sformatf("rand%0d", i), q, model_q);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
